// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared limits and divisor type for the clock divider bank
package clk_div_pkg;
  localparam int MAX_CH = 16;
  localparam int DIV_W_DEF = 16;
  typedef logic [DIV_W_DEF-1:0] div_t;
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with counter, shadowed divisor, pending flag and toggle output
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst,
`ifdef CLK_DIV_BANK_SYNC_EN
  input  logic             sync,
`endif
  input  logic             wr,
  input  logic [DIV_W-1:0] wdat,
  output logic             en,
  output logic             out,
  output logic             pend
);
  logic [DIV_W-1:0] cnt, div, shadow;
  logic off, tc, acc, rs, hit;
`ifdef CLK_DIV_BANK_SYNC_EN
  assign rs = sync;
`else
  assign rs = 1'b0;
`endif
  assign off = div == '0;
  assign tc = ~off & (cnt == div - 1'b1);
  assign acc = wr & ~pend;
  // every point where the count restarts is also where a shadowed divisor may take over
  assign hit = rs | off | tc;
  always_ff @(posedge clk_in)
    if (rst) begin
      cnt <= '0;
      div <= DIV_W'(DEFAULT_DIV);
      shadow <= '0;
      en <= 1'b0;
      out <= 1'b0;
      pend <= 1'b0;
    end else begin
      cnt <= hit ? '0 : cnt + 1'b1;
      en <= tc & ~rs;
      out <= (rs | off) ? 1'b0 : out ^ tc;
      if (tc & ~rs & acc) div <= wdat;
      else if (hit & pend) begin
        div <= shadow;
        pend <= 1'b0;
      end else if (acc) begin
        shadow <= wdat;
        pend <= 1'b1;
      end
    end
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: N_CH independent clock-enable dividers with shadowed divisor writes.
// Defining CLK_DIV_BANK_SYNC_EN adds a sync input that realigns the channels in SYNC_MASK.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEFAULT_DIV = 2
`ifdef CLK_DIV_BANK_SYNC_EN
  ,
  parameter logic [N_CH-1:0] SYNC_MASK = '1
`endif
) (
  input  logic                                   clk_in,
  input  logic                                   rst,
`ifdef CLK_DIV_BANK_SYNC_EN
  input  logic                                   sync,
`endif
  input  logic                                   cfg_valid,
  output logic                                   cfg_ready,
  input  logic [(N_CH > 1 ? $clog2(N_CH) : 1)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]                       cfg_div,
  output logic [N_CH-1:0]                        clk_en,
  output logic [N_CH-1:0]                        clk_out,
  output logic [N_CH-1:0]                        pending
);
  logic [N_CH-1:0] sel;
  // an out-of-range channel selects nothing, so it reads ready and the write is dropped
  assign cfg_ready = ~|(sel & pending);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign sel[g] = 32'(cfg_ch) == g;
    clk_div_chan #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .clk_in(clk_in),
      .rst(rst),
`ifdef CLK_DIV_BANK_SYNC_EN
      .sync(sync & SYNC_MASK[g]),
`endif
      .wr(cfg_valid & sel[g]),
      .wdat(cfg_div),
      .en(clk_en[g]),
      .out(clk_out[g]),
      .pend(pending[g])
    );
  end
endmodule
